// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: decodes the mult/div/mfhi/mthi/mflo/mtlo Funct group and runs
// a shift-add multiplier or a restoring divider, one iteration per RUN cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_mul_q, is_mul_d;
    logic               signed_q, signed_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Decode
    logic op_md, op_mul, op_signed, op_mthi, op_mtlo, accept;

    always_comb begin
        op_md     = (Funct[5:2] == 4'b0110);
        op_mul    = ~Funct[1];
        op_signed = ~Funct[0];
        op_mthi   = (Funct == 6'b010001);
        op_mtlo   = (Funct == 6'b010011);
        accept    = start && (state_q == StIdle);
    end

    // Operand magnitudes
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        mag_a = (op_signed && A[WIDTH-1]) ? -A : A;
        mag_b = (op_signed && B[WIDTH-1]) ? -B : B;
    end

    // Iteration datapath; the low half of acc holds the multiplier / quotient bits.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, mul_full;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        mul_ext_a = {{WIDTH{1'b0}}, opnd_q};
        mul_ext_b = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        mul_full  = mul_ext_a * mul_ext_b;
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        div_step  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Sign correction applied in FIX
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    always_comb begin
        neg_res  = signed_q && (sign_a_q ^ sign_b_q);
        prod_fix = neg_res ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        quo_fix  = neg_res ? -quo : quo;
        rem_fix  = (signed_q && sign_a_q) ? -rem : rem;
    end

    logic last_iter;

    always_comb begin
        last_iter = ((FAST_MUL != 0) && is_mul_q) || (cnt_q == CntW'(WIDTH - 1));
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && op_md) state_d = StRun;
            StRun:   if (last_iter) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath next state
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        is_mul_d = is_mul_q;
        signed_d = signed_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = (state_q == StFix);
        unique case (state_q)
            StIdle: begin
                if (accept && op_md) begin
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, (op_mul ? mag_b : mag_a)};
                    opnd_d   = op_mul ? mag_a : mag_b;
                    a_raw_d  = A;
                    is_mul_d = op_mul;
                    signed_d = op_signed;
                    sign_a_d = A[WIDTH-1];
                    sign_b_d = B[WIDTH-1];
                    b_zero_d = (B == '0);
                end else if (accept && op_mthi) begin
                    hi_d = A;
                end else if (accept && op_mtlo) begin
                    lo_d = A;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_mul_q) begin
                    acc_d = (FAST_MUL != 0) ? mul_full : mul_step;
                end else begin
                    acc_d = div_step;
                end
            end
            StFix: begin
                if (is_mul_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            is_mul_q <= 1'b0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            is_mul_q <= is_mul_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit (iterative and single-cycle multiply builds)
// against an arithmetic model of HI/LO results and issue/latency timing.
module tb_muldiv_unit;

    localparam logic [5:0] FMfhi  = 6'h10;
    localparam logic [5:0] FMthi  = 6'h11;
    localparam logic [5:0] FMflo  = 6'h12;
    localparam logic [5:0] FMtlo  = 6'h13;
    localparam logic [5:0] FMult  = 6'h18;
    localparam logic [5:0] FMultu = 6'h19;
    localparam logic [5:0] FDiv   = 6'h1A;
    localparam logic [5:0] FDivu  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s, start_f;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        busy_s, done_s, busy_f, done_f;
    logic [31:0] hi_s, lo_s, hi_f, lo_f;

    logic        sel_f;
    logic        obs_busy, obs_done;
    logic [31:0] obs_hi, obs_lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .FAST_MUL(0)) u_dut_slow (
        .clk(clk), .reset(reset), .start(start_s), .Funct(funct), .A(a), .B(b),
        .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
    );

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1)) u_dut_fast (
        .clk(clk), .reset(reset), .start(start_f), .Funct(funct), .A(a), .B(b),
        .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f)
    );

    assign obs_busy = sel_f ? busy_f : busy_s;
    assign obs_done = sel_f ? done_f : done_s;
    assign obs_hi   = sel_f ? hi_f : hi_s;
    assign obs_lo   = sel_f ? lo_f : lo_s;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {hi, lo} an op should leave behind, from plain signed/unsigned arithmetic
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x,
                                           input logic [31:0] y);
        longint p;
        int     q, r;
        case (f)
            FMult: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            FMultu: return {32'b0, x} * {32'b0, y};
            FDiv: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            FDivu: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        funct = f;
        a     = x;
        b     = y;
        if (sel_f) start_f = 1'b1;
        else start_s = 1'b1;
        step();
        start_s = 1'b0;
        start_f = 1'b0;
    endtask

    // Counts remaining busy cycles, then checks the done cycle contents.
    task automatic finish_op(input string tag, input int exp_busy, input logic [63:0] exp_hl);
        int n = 0;
        while (obs_busy && n < 100) begin
            n++;
            step();
        end
        check_eq({tag, ":busy_cycles"}, 64'(n), 64'(exp_busy));
        check_eq({tag, ":done"}, 64'(obs_done), 64'd1);
        check_eq({tag, ":hi"}, 64'(obs_hi), 64'(exp_hl[63:32]));
        check_eq({tag, ":lo"}, 64'(obs_lo), 64'(exp_hl[31:0]));
    endtask

    task automatic do_md(input string tag, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        logic [63:0] r;
        int          nb;
        r  = ref_op(f, x, y);
        nb = (sel_f && !f[1]) ? 2 : 33;
        issue(f, x, y);
        finish_op(tag, nb, r);
        if (!sel_f) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        step();
        check_eq({tag, ":done_1cyc"}, 64'(obs_done), 64'd0);
    endtask

    task automatic do_move(input string tag, input logic [5:0] f, input logic [31:0] x);
        issue(f, x, 32'h0);
        if (f == FMthi) m_hi = x;
        if (f == FMtlo) m_lo = x;
        check_eq({tag, ":busy"}, 64'(obs_busy), 64'd0);
        check_eq({tag, ":done"}, 64'(obs_done), 64'd0);
        check_eq({tag, ":hi"}, 64'(obs_hi), 64'(m_hi));
        check_eq({tag, ":lo"}, 64'(obs_lo), 64'(m_lo));
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] x, y;
        int          pulses;

        reset   = 1'b1;
        start_s = 1'b0;
        start_f = 1'b0;
        sel_f   = 1'b0;
        funct   = 6'h0;
        a       = 32'h0;
        b       = 32'h0;
        m_hi    = 32'h0;
        m_lo    = 32'h0;
        step();
        step();
        check_eq("rst:busy", 64'(busy_s), 64'd0);
        check_eq("rst:done", 64'(done_s), 64'd0);
        check_eq("rst:hi", 64'(hi_s), 64'd0);
        check_eq("rst:lo", 64'(lo_s), 64'd0);
        check_eq("rst:fast_busy", 64'(busy_f), 64'd0);
        reset = 1'b0;
        step();

        do_md("t1_mult", FMult, 32'hFFFF_FFFF, 32'd2);
        check_eq("t1_hi_const", 64'(hi_s), 64'hFFFF_FFFF);
        check_eq("t1_lo_const", 64'(lo_s), 64'hFFFF_FFFE);
        do_md("t2_multu", FMultu, 32'hFFFF_FFFF, 32'd2);
        check_eq("t2_hi_const", 64'(hi_s), 64'h1);
        do_md("t3_div_neg", FDiv, -32'sd7, 32'd2);
        check_eq("t3_lo_const", 64'(lo_s), 64'hFFFF_FFFD);
        do_md("t3_divu", FDivu, 32'd7, 32'd2);
        do_md("t3_div_ovf", FDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("t3_ovf_lo_const", 64'(lo_s), 64'h8000_0000);
        do_md("t4_divu_zero", FDivu, 32'd7, 32'd0);
        check_eq("t4_hi_const", 64'(hi_s), 64'd7);
        do_move("t5_mthi", FMthi, 32'd5);
        do_move("t5_mflo_nop", FMflo, 32'hDEAD_BEEF);

        // mtlo issued while busy must be dropped
        issue(FDiv, 32'd100, 32'd7);
        funct   = FMtlo;
        a       = 32'd9;
        start_s = 1'b1;
        step();
        step();
        start_s = 1'b0;
        finish_op("t5_mtlo_busy", 31, ref_op(FDiv, 32'd100, 32'd7));
        // back-to-back mult issued in the done cycle
        issue(FMult, 32'd1234, -32'sd3);
        check_eq("t5_b2b_busy", 64'(busy_s), 64'd1);
        finish_op("t5_b2b", 33, ref_op(FMult, 32'd1234, -32'sd3));
        {m_hi, m_lo} = ref_op(FMult, 32'd1234, -32'sd3);
        step();

        // fast multiply build
        sel_f = 1'b1;
        do_md("t2_fast_multu", FMultu, 32'hFFFF_FFFF, 32'd2);
        do_md("t2_fast_mult", FMult, 32'hFFFF_FFFF, 32'd2);
        do_md("fast_div", FDiv, -32'sd100, 32'd9);
        for (int i = 0; i < 6; i++) begin
            do_md("fast_rand_mult", (i % 2 == 0) ? FMult : FMultu, $urandom, $urandom);
        end
        sel_f = 1'b0;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: f = FMfhi;
                1: f = FMthi;
                2: f = FMflo;
                3: f = FMtlo;
                4: f = FMult;
                5: f = FMultu;
                6: f = FDiv;
                default: f = FDivu;
            endcase
            case ($urandom_range(0, 4))
                0: begin x = 32'($urandom_range(0, 31)) - 32'd16; y = 32'($urandom_range(0, 31)) - 32'd16; end
                1: begin x = $urandom; y = 32'h0; end
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                default: begin x = $urandom; y = $urandom >> $urandom_range(0, 31); end
            endcase
            if (f[3]) do_md("rand_md", f, x, y);
            else do_move("rand_move", f, x);
        end

        // reset during RUN cycle 10 aborts cleanly
        issue(FMult, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) step();
        check_eq("t6_pre_busy", 64'(busy_s), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_busy", 64'(busy_s), 64'd0);
        check_eq("t6_done", 64'(done_s), 64'd0);
        check_eq("t6_hi", 64'(hi_s), 64'd0);
        check_eq("t6_lo", 64'(lo_s), 64'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            step();
            if (done_s || busy_s) pulses++;
        end
        check_eq("t6_no_done", 64'(pulses), 64'd0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        do_md("post_rst_div", FDiv, 32'd50, -32'sd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
